// File: rtl/parking_occupancy_counter.sv
`default_nettype none
// ============================================================================
// parking_occupancy_counter : tracks live lot occupancy from enter/exit pulses
// Revision 1.0 - initial release
// ============================================================================
module parking_occupancy_counter #(
  parameter int CAPACITY = 25,
  parameter int TOTAL_W  = 16,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               exit,
  input  logic               clear,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow_err,
  output logic               underflow_err,
  output logic [TOTAL_W-1:0] total_entered,
  output logic [CNT_W-1:0]   peak
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_capacity = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_count, w_count;
  logic [CNT_W-1:0]   r_peak, w_peak;
  logic [TOTAL_W-1:0] r_total, w_total;
  logic               r_ovf, w_ovf;
  logic               r_unf, w_unf;
  logic [CNT_W-1:0]   w_inc, w_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_peak  <= '0;
      r_total <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_peak  <= w_peak;
      r_total <= w_total;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end
  end

  // Increment/decrement are only used from states where they cannot wrap.
  assign w_inc = r_count + c_one;
  assign w_dec = r_count - c_one;

  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_peak  = r_peak;
    w_total = r_total;
    w_ovf   = r_ovf;
    w_unf   = r_unf;
    if (clear) begin
      w_state = ST_EMPTY;
      w_count = '0;
      w_peak  = '0;
      w_total = '0;
      w_ovf   = 1'b0;
      w_unf   = 1'b0;
    end else begin
      if (enter && !exit) begin
        if (r_state == ST_FULL) begin
          w_ovf = 1'b1;
        end else begin
          w_count = w_inc;
          w_total = r_total + TOTAL_W'(1);
          w_state = (w_inc == c_capacity) ? ST_FULL : ST_PARTIAL;
        end
      end else if (exit && !enter) begin
        if (r_state == ST_EMPTY) begin
          w_unf = 1'b1;
        end else begin
          w_count = w_dec;
          w_state = (w_dec == '0) ? ST_EMPTY : ST_PARTIAL;
        end
      end else if (enter && exit) begin
        // Simultaneous pulses: one car in, one out; net occupancy unchanged.
        w_total = r_total + TOTAL_W'(1);
      end
      if (w_count > r_peak) begin
        w_peak = w_count;
      end
    end
  end

  assign count         = r_count;
  assign full          = (r_state == ST_FULL);
  assign empty         = (r_state == ST_EMPTY);
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
  assign total_entered = r_total;
  assign peak          = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_parking_occupancy_counter.sv
`default_nettype none
// Bench for parking_occupancy_counter: two instances (25/16 and 4/3) share stimulus
// and are compared against an arithmetic occupancy model.
module tb_parking_occupancy_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enter = 1'b0, exit = 1'b0, clear = 1'b0;

  logic [4:0]  cnt_a, pk_a;
  logic [15:0] tot_a;
  logic        full_a, empty_a, ovf_a, unf_a;
  logic [2:0]  cnt_b, pk_b;
  logic [2:0]  tot_b;
  logic        full_b, empty_b, ovf_b, unf_b;

  int checks = 0;
  int failures = 0;

  // Model state, index 0 = instance A, 1 = instance B
  int m_cap [2] = '{25, 4};
  int m_mod [2] = '{65536, 8};
  int m_cnt [2];
  int m_tot [2];
  int m_pk  [2];
  bit m_ovf [2];
  bit m_unf [2];

  typedef struct {
    bit e, x, c;
    int cnt, tot, pk;
    bit emp, ovf, unf;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  parking_occupancy_counter dut_a (
    .clk(clk), .reset(reset), .enter(enter), .exit(exit), .clear(clear),
    .count(cnt_a), .full(full_a), .empty(empty_a), .overflow_err(ovf_a),
    .underflow_err(unf_a), .total_entered(tot_a), .peak(pk_a)
  );

  parking_occupancy_counter #(.CAPACITY(4), .TOTAL_W(3)) dut_b (
    .clk(clk), .reset(reset), .enter(enter), .exit(exit), .clear(clear),
    .count(cnt_b), .full(full_b), .empty(empty_b), .overflow_err(ovf_b),
    .underflow_err(unf_b), .total_entered(tot_b), .peak(pk_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_tot[k] = 0; m_pk[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end
  endtask

  task automatic model_apply(input bit e, input bit x, input bit c);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_cnt[k] = 0; m_tot[k] = 0; m_pk[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
        if (e && !x) begin
          if (m_cnt[k] == m_cap[k]) m_ovf[k] = 1;
          else begin
            m_cnt[k] = m_cnt[k] + 1;
            m_tot[k] = (m_tot[k] + 1) % m_mod[k];
          end
        end else if (x && !e) begin
          if (m_cnt[k] == 0) m_unf[k] = 1;
          else m_cnt[k] = m_cnt[k] - 1;
        end else if (e && x) begin
          m_tot[k] = (m_tot[k] + 1) % m_mod[k];
        end
        if (m_cnt[k] > m_pk[k]) m_pk[k] = m_cnt[k];
      end
    end
  endtask

  task automatic check_models();
    chk("a_count", int'(cnt_a), m_cnt[0]);
    chk("a_full",  int'(full_a), int'(m_cnt[0] == m_cap[0]));
    chk("a_empty", int'(empty_a), int'(m_cnt[0] == 0));
    chk("a_ovf",   int'(ovf_a), int'(m_ovf[0]));
    chk("a_unf",   int'(unf_a), int'(m_unf[0]));
    chk("a_total", int'(tot_a), m_tot[0]);
    chk("a_peak",  int'(pk_a), m_pk[0]);
    chk("b_count", int'(cnt_b), m_cnt[1]);
    chk("b_full",  int'(full_b), int'(m_cnt[1] == m_cap[1]));
    chk("b_empty", int'(empty_b), int'(m_cnt[1] == 0));
    chk("b_ovf",   int'(ovf_b), int'(m_ovf[1]));
    chk("b_unf",   int'(unf_b), int'(m_unf[1]));
    chk("b_total", int'(tot_b), m_tot[1]);
    chk("b_peak",  int'(pk_b), m_pk[1]);
  endtask

  task automatic step(input bit e, input bit x, input bit c);
    @(negedge clk);
    enter = e; exit = x; clear = c;
    @(posedge clk);
    model_apply(e, x, c);
    #1;
    check_models();
  endtask

  task automatic do_reset();
    @(negedge clk);
    enter = 0; exit = 0; clear = 0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    check_models();
  endtask

  initial begin
    vecs[0]  = '{1,0,0, 1,1,1, 0,0,0};
    vecs[1]  = '{1,0,0, 2,2,2, 0,0,0};
    vecs[2]  = '{1,0,0, 3,3,3, 0,0,0};
    vecs[3]  = '{1,0,0, 4,4,4, 0,0,0};
    vecs[4]  = '{1,0,0, 5,5,5, 0,0,0};
    vecs[5]  = '{0,1,0, 4,5,5, 0,0,0};
    vecs[6]  = '{0,1,0, 3,5,5, 0,0,0};
    vecs[7]  = '{1,1,0, 3,6,5, 0,0,0};
    vecs[8]  = '{1,0,1, 0,0,0, 1,0,0};
    vecs[9]  = '{0,1,0, 0,0,0, 1,0,1};
    vecs[10] = '{1,0,0, 1,1,1, 0,0,1};
    vecs[11] = '{1,1,0, 1,2,1, 0,0,1};
    vecs[12] = '{0,0,1, 0,0,0, 1,0,0};

    // Reset state
    do_reset();
    chk("reset_count", int'(cnt_a), 0);
    chk("reset_empty", int'(empty_a), 1);

    // Directed table on the 25-space instance
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].e, vecs[i].x, vecs[i].c);
      chk($sformatf("vec%0d_count", i), int'(cnt_a), vecs[i].cnt);
      chk($sformatf("vec%0d_total", i), int'(tot_a), vecs[i].tot);
      chk($sformatf("vec%0d_peak", i),  int'(pk_a),  vecs[i].pk);
      chk($sformatf("vec%0d_empty", i), int'(empty_a), int'(vecs[i].emp));
      chk($sformatf("vec%0d_ovf", i),   int'(ovf_a), int'(vecs[i].ovf));
      chk($sformatf("vec%0d_unf", i),   int'(unf_a), int'(vecs[i].unf));
    end

    // Fill the 4-space lot, then overflow
    do_reset();
    repeat (4) step(1, 0, 0);
    chk("b_fill_full", int'(full_b), 1);
    chk("b_fill_count", int'(cnt_b), 4);
    step(1, 0, 0);
    chk("b_over_count", int'(cnt_b), 4);
    chk("b_over_err", int'(ovf_b), 1);
    chk("b_over_total", int'(tot_b), 4);
    step(1, 1, 0);
    chk("b_full_pair_count", int'(cnt_b), 4);
    chk("b_full_pair_unf", int'(unf_b), 0);
    step(0, 1, 0);
    chk("b_exit_from_full", int'(cnt_b), 3);
    chk("b_ovf_sticky", int'(ovf_b), 1);

    // Simultaneous pulses while empty
    step(0, 0, 1);
    step(1, 1, 0);
    chk("empty_pair_unf", int'(unf_b), 0);
    chk("empty_pair_count", int'(cnt_b), 0);

    // Lifetime counter wrap on the 3-bit instance
    step(0, 0, 1);
    repeat (9) begin
      step(1, 0, 0);
      step(0, 1, 0);
    end
    chk("b_total_wrap", int'(tot_b), 1);
    chk("a_total_nowrap", int'(tot_a), 9);

    // Async reset mid-pulse takes effect before the next clock edge
    step(1, 0, 0);
    step(1, 0, 0);
    @(negedge clk);
    enter = 1;
    #2 reset = 1;
    #1;
    chk("async_count_a", int'(cnt_a), 0);
    chk("async_count_b", int'(cnt_b), 0);
    chk("async_total_a", int'(tot_a), 0);
    chk("async_empty_b", int'(empty_b), 1);
    enter = 0;
    do_reset();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit e, x, c;
      e = ($urandom_range(0, 99) < 55);
      x = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 63) == 0);
      step(e, x, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
